// File: rtl/oven_plant_model.sv
// rtl/oven_plant_model.sv - behavioural oven thermal plant driven by a heater command
// Optional door model enabled by defining OVEN_PLANT_DOOR_EN (adds the door_open port).
module oven_plant_model #(
  parameter int TICK_DIV  = 50000000,
  parameter int TEMP_W    = 9,
  parameter int AMBIENT   = 70,
  parameter int MAX_TEMP  = 500,
  parameter int LAG_TICKS = 2,
  parameter int HEAT_STEP = 2,
  parameter int COOL_DIV  = 2,
  parameter int DOOR_LOSS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              heat_on,
`ifdef OVEN_PLANT_DOOR_EN
  input  logic              door_open,
`endif
  output logic [TEMP_W-1:0] temp,
  output logic              tick,
  output logic [1:0]        state,
  output logic              at_max,
  output logic              at_ambient
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LAG_W  = $clog2(LAG_TICKS + 1);
  localparam int COOL_W = $clog2(COOL_DIV + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [LAG_W-1:0]  LAG_LAST  = LAG_W'(LAG_TICKS - 1);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOL_DIV - 1);

  localparam logic [TEMP_W-1:0] AMB_T  = TEMP_W'(AMBIENT);
  localparam logic [TEMP_W-1:0] MAX_T  = TEMP_W'(MAX_TEMP);
  localparam logic [TEMP_W-1:0] LOSS_T = TEMP_W'(DOOR_LOSS);
  localparam logic [TEMP_W:0]   AMB_X  = (TEMP_W+1)'(AMBIENT);
  localparam logic [TEMP_W:0]   MAX_X  = (TEMP_W+1)'(MAX_TEMP);
  localparam logic [TEMP_W:0]   STEP_X = (TEMP_W+1)'(HEAT_STEP);
  localparam logic [TEMP_W:0]   LOSS_X = (TEMP_W+1)'(DOOR_LOSS);

  typedef enum logic [1:0] {COLD = 2'd0, WARMUP = 2'd1, HEATING = 2'd2, COOLING = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt;
  logic [LAG_W-1:0]    lag_cnt, lag_d;
  logic [COOL_W-1:0]   cool_phase, phase_d;
  logic [TEMP_W-1:0]   temp_d;
  logic                tick_edge;
  logic                door_act;
  logic [TEMP_W:0]     temp_x;
  logic [TEMP_W:0]     heat_sum;
  logic [TEMP_W-1:0]   heat_val;
  logic [TEMP_W-1:0]   cool_val;
  logic [TEMP_W-1:0]   door_val;

`ifdef OVEN_PLANT_DOOR_EN
  assign door_act = door_open;
`else
  assign door_act = 1'b0;
`endif

  assign tick_edge = (div_cnt == DIV_LAST);

  // Candidate temperatures, widened by one bit so clamping sees overflow
  assign temp_x   = {1'b0, temp};
  assign heat_sum = temp_x + STEP_X;
  assign heat_val = (heat_sum > MAX_X) ? MAX_T : heat_sum[TEMP_W-1:0];
  assign cool_val = (temp_x > AMB_X) ? temp - 1'b1 : AMB_T;
  assign door_val = (temp_x >= AMB_X + LOSS_X) ? temp - LOSS_T : AMB_T;

  // State, temperature, lag and cooling phase register; updates only on tick edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      tick       <= 1'b0;
      state_q    <= COLD;
      temp       <= AMB_T;
      lag_cnt    <= '0;
      cool_phase <= '0;
    end else begin
      div_cnt <= tick_edge ? '0 : div_cnt + 1'b1;
      tick    <= tick_edge;
      if (tick_edge) begin
        state_q    <= state_d;
        temp       <= temp_d;
        lag_cnt    <= lag_d;
        cool_phase <= phase_d;
      end
    end
  end

  // Next-state and next-temperature decision for the coming tick
  always_comb begin
    state_d = state_q;
    temp_d  = temp;
    lag_d   = lag_cnt;
    phase_d = cool_phase;
    case (state_q)
      COLD: begin
        temp_d = AMB_T;
        if (heat_on) begin
          state_d = WARMUP;
          lag_d   = '0;
        end
      end
      WARMUP: begin
        if (!heat_on) begin
          state_d = (temp_x > AMB_X) ? COOLING : COLD;
          phase_d = '0;
        end else if (!door_act) begin
          // an open door stalls warm-up without losing progress
          if (lag_cnt == LAG_LAST) begin
            state_d = HEATING;
            temp_d  = heat_val;
          end else begin
            lag_d = lag_cnt + 1'b1;
          end
        end
      end
      HEATING: begin
        if (door_act) begin
          temp_d  = door_val;
          phase_d = '0;
          if (!heat_on) state_d = COOLING;
        end else if (heat_on) begin
          temp_d = heat_val;
        end else begin
          state_d = COOLING;
          phase_d = '0;
        end
      end
      default: begin
        if (door_act) begin
          temp_d  = door_val;
          phase_d = '0;
        end
        if (heat_on) begin
          state_d = WARMUP;
          lag_d   = '0;
        end else if (!door_act) begin
          if (cool_phase == COOL_LAST) begin
            temp_d  = cool_val;
            phase_d = '0;
          end else begin
            phase_d = cool_phase + 1'b1;
          end
        end
      end
    endcase
    // cooling that lands on ambient is simply cold
    if (state_d == COOLING && temp_d == AMB_T) state_d = COLD;
  end

  // Status outputs decoded from the registered state and temperature
  always_comb begin
    state      = state_q;
    at_max     = (temp == MAX_T);
    at_ambient = (temp == AMB_T);
  end

endmodule

// File: tb/tb_oven_plant_model.sv
// tb/tb_oven_plant_model.sv - directed self-checking bench for oven_plant_model
module tb_oven_plant_model;

  localparam int TICK_DIV = 4;
  localparam int TEMP_W   = 9;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              heat_on;
  logic              door_open;
  logic [TEMP_W-1:0] temp;
  logic              tick;
  logic [1:0]        state;
  logic              at_max;
  logic              at_ambient;

  int n_checks = 0;
  int n_fail   = 0;

  oven_plant_model #(
    .TICK_DIV(TICK_DIV), .TEMP_W(TEMP_W), .AMBIENT(70), .MAX_TEMP(80),
    .LAG_TICKS(2), .HEAT_STEP(2), .COOL_DIV(2), .DOOR_LOSS(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .heat_on(heat_on),
`ifdef OVEN_PLANT_DOOR_EN
    .door_open(door_open),
`endif
    .temp(temp),
    .tick(tick),
    .state(state),
    .at_max(at_max),
    .at_ambient(at_ambient)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next tick pulse, checking how many edges it took
  task automatic wait_tick(input string tag, input int exp_cycles);
    int cycles;
    cycles = 0;
    for (int i = 0; i < 4 * TICK_DIV; i++) begin
      @(negedge clk);
      cycles++;
      if (tick) break;
    end
    check(tag, cycles, exp_cycles);
  endtask

  int heat_state [8] = '{1, 1, 2, 2, 2, 2, 2, 2};
  int heat_temp  [8] = '{70, 70, 72, 74, 76, 78, 80, 80};

  initial begin
    rst_n     = 1'b0;
    heat_on   = 1'b0;
    door_open = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_temp", temp, 70);
    check("rst_state", state, 0);
    check("rst_tick", tick, 0);
    check("rst_at_amb", at_ambient, 1);
    check("rst_at_max", at_max, 0);

    // idle after reset release
    rst_n = 1'b1;
    wait_tick("first_tick", 4);
    check("idle_temp", temp, 70);
    check("idle_state", state, 0);
    @(negedge clk);
    check("tick_one_cycle", tick, 0);
    wait_tick("tick_period", 3);
    check("idle_temp2", temp, 70);

    // continuous heating up to saturation
    heat_on = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_tick("heat_period", 4);
      check($sformatf("heat_state_t%0d", k + 1), state, heat_state[k]);
      check($sformatf("heat_temp_t%0d", k + 1), temp, heat_temp[k]);
    end
    check("heat_at_max", at_max, 1);

    // cooling back to ambient, one degree every two ticks
    heat_on = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      wait_tick("cool_period", 4);
      check($sformatf("cool_temp_t%0d", k), temp, 80 - (k - 1) / 2);
      check($sformatf("cool_state_t%0d", k), state, (k == 21) ? 0 : 3);
    end
    check("cool_at_amb", at_ambient, 1);

    // short heat request aborted during warm-up
    heat_on = 1'b1;
    wait_tick("abort_period", 4);
    check("abort_warmup", state, 1);
    heat_on = 1'b0;
    wait_tick("abort_period2", 4);
    check("abort_state", state, 0);
    check("abort_temp", temp, 70);

    // single-cycle pulse between ticks is invisible
    heat_on = 1'b1;
    @(negedge clk);
    heat_on = 1'b0;
    wait_tick("pulse_period", 3);
    check("pulse_state", state, 0);
    wait_tick("pulse_period2", 4);
    check("pulse_state2", state, 0);

    // asynchronous reset in the middle of heating
    heat_on = 1'b1;
    for (int k = 0; k < 5; k++) wait_tick("pre_rst_period", 4);
    check("pre_rst_temp", temp, 76);
    check("pre_rst_tick", tick, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_temp", temp, 70);
    check("async_rst_state", state, 0);
    check("async_rst_tick", tick, 0);
    @(negedge clk);
    heat_on = 1'b0;
    rst_n   = 1'b1;
    wait_tick("post_rst_tick", 4);
    check("post_rst_state", state, 0);

`ifdef OVEN_PLANT_DOOR_EN
    // door opened while heating at 78
    heat_on = 1'b1;
    for (int k = 0; k < 6; k++) wait_tick("door_pre_period", 4);
    check("door_pre_temp", temp, 78);
    door_open = 1'b1;
    wait_tick("door_period", 4);
    check("door_temp1", temp, 74);
    check("door_state1", state, 2);
    wait_tick("door_period2", 4);
    check("door_temp2", temp, 70);
    check("door_state2", state, 2);
    door_open = 1'b0;
    wait_tick("door_period3", 4);
    check("door_temp3", temp, 72);
    check("door_state3", state, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/oven_plant_model.md
# oven_plant_model

Behavioural thermal plant for the FPGA oven: the other end of the oven controller's heat-command interface. It consumes the controller's heater command and produces the oven temperature the controller regulates against. Temperature evolves once per prescaled tick with heater lag, linear heating, slow cooling and ambient/maximum saturation. Used in place of a real sensor on the board and as the closed-loop partner in controller benches.

## Interface
- TICK_DIV, 50000000, clk cycles per plant tick (≥2)
- TEMP_W, 9, temperature width in bits
- AMBIENT, 70, reset/floor temperature
- MAX_TEMP, 500, saturation ceiling (< 2^TEMP_W, > AMBIENT)
- LAG_TICKS, 2, heater warm-up ticks before temperature rises (≥1)
- HEAT_STEP, 2, degrees added per tick while heating
- COOL_DIV, 2, ticks per 1-degree drop while cooling (≥1)
- DOOR_LOSS, 4, degrees lost per tick with door open (macro only)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- heat_on  in  1  heater command from controller, level
- door_open  in  1  door sensor, level (only with OVEN_PLANT_DOOR_EN)
- temp  out  TEMP_W  current oven temperature
- tick  out  1  one-cycle pulse, high in the cycle temp shows a tick's update
- state  out  2  COLD=0, WARMUP=1, HEATING=2, COOLING=3
- at_max  out  1  temp == MAX_TEMP
- at_ambient  out  1  temp == AMBIENT

## Operation
- Divider div_cnt counts 0..TICK_DIV-1, wraps; the edge where div_cnt==TICK_DIV-1 is a tick edge.
- All state/temp/lag/phase updates happen only on tick edges; heat_on (and door_open) sampled there. Between ticks everything holds.
- COLD: heat_on=1 → WARMUP, lag_cnt=0; else stay, temp=AMBIENT.
- WARMUP: heat_on=0 → COOLING if temp>AMBIENT else COLD. heat_on=1: if lag_cnt==LAG_TICKS-1 → HEATING and temp += HEAT_STEP on this tick; else lag_cnt++ and temp unchanged.
- HEATING: heat_on=1 → temp = min(temp+HEAT_STEP, MAX_TEMP), stay. heat_on=0 → COOLING, cool_phase=0, temp unchanged.
- COOLING: heat_on=1 → WARMUP, lag_cnt=0, temp unchanged. heat_on=0: if cool_phase==COOL_DIV-1 then temp -= 1, cool_phase=0, else cool_phase++. When the new temp equals AMBIENT → COLD.
- Arithmetic: sums computed at TEMP_W+1 bits then clamped; temp never leaves [AMBIENT, MAX_TEMP].
- at_max, at_ambient are combinational from registered temp.

## Timing
- Reset (async assert, any time, incl. mid-tick or mid-heating): temp=AMBIENT, state=COLD, tick=0, div_cnt=0, lag_cnt=0, cool_phase=0; at_ambient=1, at_max=0.
- First tick pulse is the TICK_DIV-th rising edge after rst_n deassertion; then every TICK_DIV cycles.
- temp, state, tick all update on the same tick edge (registered, zero added latency).
- heat_on held from before tick n: first temperature rise at tick n+LAG_TICKS.
- heat_on changes between ticks are invisible; a pulse not spanning a tick edge is ignored.
- Saturated heating at MAX_TEMP: temp holds, state stays HEATING.

## Configuration
- OVEN_PLANT_DOOR_EN defined: door_open port exists. On a tick with door_open=1: HEATING/COOLING do temp = max(temp-DOOR_LOSS, AMBIENT), no heating, cool_phase cleared; state transitions on heat_on still apply, COOLING reaching AMBIENT → COLD; WARMUP holds lag_cnt.
- Undefined: no door_open port, behaviour identical to door_open=0.

## Test plan
Parameters TICK_DIV=4, AMBIENT=70, MAX_TEMP=80, LAG_TICKS=2, HEAT_STEP=2, COOL_DIV=2.
- Reset release, heat_on=0 → temp=70, state=0, tick first high on 4th edge, every 4 cycles after, temp stays 70.
- heat_on=1 held → tick1 state=1, tick2 temp 70, tick3 state=2 temp 72, ticks 4-7 74/76/78/80, tick8 80 with at_max=1.
- From 80, heat_on=0 → next tick state=3 temp 80; 79 two ticks later; decrement every 2 ticks; 70 and state=0 twenty ticks after entering COOLING.
- heat_on=1 for one tick then 0 (in WARMUP) → state back to 0, temp 70; 1-cycle heat_on pulse between ticks → no change.
- rst_n low mid-HEATING at temp 76, between ticks → temp 70, state 0, tick 0 immediately, without clk edge.
- OVEN_PLANT_DOOR_EN, HEATING at 78, door_open=1 with heat_on=1 → 74, 70 next tick, state stays 2; door_open=0 → rises to 72.
